// File: rtl/vtg_pkg.sv
// Shared types and constants for the video timing generator: FSM states,
// default 720p60 timing, counter width and the colour-bar lookup.
package vtg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RUN  = 2'd2
    } vtg_state_t;

    localparam int VTG_CNT_W       = 12;
    localparam int VTG_SYNC_STAGES = 2;

    localparam int VTG_H_ACTIVE  = 1280;
    localparam int VTG_H_FP      = 110;
    localparam int VTG_H_SYNC    = 40;
    localparam int VTG_H_BP      = 220;
    localparam int VTG_V_ACTIVE  = 720;
    localparam int VTG_V_FP      = 5;
    localparam int VTG_V_SYNC    = 5;
    localparam int VTG_V_BP      = 20;
    localparam int VTG_LOCK_WAIT = 1024;

    localparam int VTG_NUM_BARS = 8;

    // Entry 0 (least significant) is the leftmost bar.
    localparam logic [VTG_NUM_BARS-1:0][23:0] VTG_BAR_LUT = {
        24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
        24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
    };

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        return VTG_BAR_LUT[idx];
    endfunction

endpackage

// File: rtl/video_timing_gen_lock_qualifier.sv
// PLL lock qualification: 2-flop synchronizer, consecutive-high wait counter
// and IDLE/WAIT/RUN state machine that enables the timing counters.
import vtg_pkg::*;

module lock_qualifier #(
    parameter int LOCK_WAIT = VTG_LOCK_WAIT
) (
    input  logic clkin,
    input  logic reset,
    input  logic pll_lock,
    output logic run,
    output logic running
);

    localparam int WAIT_W = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LOCK_WAIT - 1);

    logic              sync_reg [VTG_SYNC_STAGES];
    logic              lock_s;
    vtg_state_t        state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic              running_reg;

    genvar gi;
    generate
        for (gi = 0; gi < VTG_SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clkin or posedge reset) begin
                    if (reset) sync_reg[gi] <= 1'b0;
                    else       sync_reg[gi] <= pll_lock;
                end
            end else begin : g_chain
                always_ff @(posedge clkin or posedge reset) begin
                    if (reset) sync_reg[gi] <= 1'b0;
                    else       sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign lock_s = sync_reg[VTG_SYNC_STAGES-1];

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
            running_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            running_reg  <= (state_next == RUN);
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = '0;
        case (state_reg)
            IDLE: begin
                if (lock_s) state_next = WAIT;
            end
            WAIT: begin
                if (!lock_s)                     state_next = IDLE;
                else if (wait_cnt_reg == WAIT_LAST) state_next = RUN;
                else                             wait_cnt_next = wait_cnt_reg + 1'b1;
            end
            RUN: begin
                if (!lock_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Counters stop in the very cycle lock is seen low, so outputs idle one clock later.
    assign run     = (state_reg == RUN) && lock_s;
    assign running = running_reg;

endmodule

// File: rtl/video_timing_gen.sv
// Pixel-clock video timing generator: h/v counters, registered sync/de/coordinate
// decode and, when VTG_PATTERN_EN is defined, an 8-bar colour pattern on rgb.
import vtg_pkg::*;

module video_timing_gen #(
    parameter int   H_ACTIVE  = VTG_H_ACTIVE,
    parameter int   H_FP      = VTG_H_FP,
    parameter int   H_SYNC    = VTG_H_SYNC,
    parameter int   H_BP      = VTG_H_BP,
    parameter int   V_ACTIVE  = VTG_V_ACTIVE,
    parameter int   V_FP      = VTG_V_FP,
    parameter int   V_SYNC    = VTG_V_SYNC,
    parameter int   V_BP      = VTG_V_BP,
    parameter logic HS_POL    = 1'b1,
    parameter logic VS_POL    = 1'b1,
    parameter int   LOCK_WAIT = VTG_LOCK_WAIT
) (
    input  logic        clkin,
    input  logic        reset,
    input  logic        pll_lock,
    output logic        running,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        frame_start,
    output logic [23:0] rgb
);

    localparam int CW = VTG_CNT_W;

    localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] H_LAST   = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] V_LAST   = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic          run;
    logic [CW-1:0] h_cnt_reg, v_cnt_reg;
    logic          de_next, hsync_next, vsync_next, frame_start_next;
    logic [CW-1:0] x_next, y_next;
    logic          de_reg, hsync_reg, vsync_reg, frame_start_reg;
    logic [CW-1:0] x_reg, y_reg;

    lock_qualifier #(
        .LOCK_WAIT (LOCK_WAIT)
    ) u_lock_qualifier (
        .clkin    (clkin),
        .reset    (reset),
        .pll_lock (pll_lock),
        .run      (run),
        .running  (running)
    );

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else if (!run) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else if (h_cnt_reg == H_LAST) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 1'b1;
        end else begin
            h_cnt_reg <= h_cnt_reg + 1'b1;
        end
    end

    always_comb begin
        de_next          = run && (h_cnt_reg < H_ACT_C) && (v_cnt_reg < V_ACT_C);
        hsync_next       = (run && (h_cnt_reg >= HS_START) && (h_cnt_reg < HS_END)) ? HS_POL : ~HS_POL;
        vsync_next       = (run && (v_cnt_reg >= VS_START) && (v_cnt_reg < VS_END)) ? VS_POL : ~VS_POL;
        x_next           = de_next ? h_cnt_reg : '0;
        y_next           = de_next ? v_cnt_reg : '0;
        frame_start_next = run && (h_cnt_reg == '0) && (v_cnt_reg == '0);
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            de_reg          <= 1'b0;
            hsync_reg       <= ~HS_POL;
            vsync_reg       <= ~VS_POL;
            x_reg           <= '0;
            y_reg           <= '0;
            frame_start_reg <= 1'b0;
        end else begin
            de_reg          <= de_next;
            hsync_reg       <= hsync_next;
            vsync_reg       <= vsync_next;
            x_reg           <= x_next;
            y_reg           <= y_next;
            frame_start_reg <= frame_start_next;
        end
    end

    assign de          = de_reg;
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign x           = x_reg;
    assign y           = y_reg;
    assign frame_start = frame_start_reg;

`ifdef VTG_PATTERN_EN
    localparam logic [CW-1:0] BAR_W    = CW'(H_ACTIVE / VTG_NUM_BARS);
    localparam logic [CW-1:0] BAR_LAST = CW'(VTG_NUM_BARS - 1);

    logic [CW-1:0] bar_idx;
    logic [23:0]   rgb_next, rgb_reg;

    // Any remainder pixels past the eighth bar stay on the last (black) bar.
    always_comb begin
        bar_idx  = h_cnt_reg / BAR_W;
        rgb_next = '0;
        if (de_next) begin
            rgb_next = (bar_idx > BAR_LAST) ? bar_colour(3'd7) : bar_colour(bar_idx[2:0]);
        end
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) rgb_reg <= '0;
        else       rgb_reg <= rgb_next;
    end

    assign rgb = rgb_reg;
`else
    assign rgb = '0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen using a reduced timing (25x14 frame,
// LOCK_WAIT=16) plus a second, inverted-polarity instance on the same inputs.
`timescale 1ns/1ps

module tb_video_timing_gen;

    localparam int FRAME = 350;

    logic        clkin = 1'b0;
    logic        reset;
    logic        pll_lock;

    logic        running, hsync, vsync, de, frame_start;
    logic [11:0] x, y;
    logic [23:0] rgb;

    logic        n_running, n_hsync, n_vsync, n_de, n_frame_start;
    logic [11:0] n_x, n_y;
    logic [23:0] n_rgb;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    logic        de_s  [FRAME];
    logic        hs_s  [FRAME];
    logic        vs_s  [FRAME];
    logic        fs_s  [FRAME];
    logic        nhs_s [FRAME];
    logic        nvs_s [FRAME];
    logic [11:0] x_s   [FRAME];
    logic [11:0] y_s   [FRAME];
    logic [23:0] rgb_s [FRAME];

    always #5 clkin = ~clkin;

    video_timing_gen #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (4),
        .V_ACTIVE (8),  .V_FP (1), .V_SYNC (2), .V_BP (3),
        .HS_POL (1'b1), .VS_POL (1'b1), .LOCK_WAIT (16)
    ) dut (
        .clkin (clkin), .reset (reset), .pll_lock (pll_lock),
        .running (running), .hsync (hsync), .vsync (vsync), .de (de),
        .x (x), .y (y), .frame_start (frame_start), .rgb (rgb)
    );

    video_timing_gen #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (4),
        .V_ACTIVE (8),  .V_FP (1), .V_SYNC (2), .V_BP (3),
        .HS_POL (1'b0), .VS_POL (1'b0), .LOCK_WAIT (16)
    ) dut_neg (
        .clkin (clkin), .reset (reset), .pll_lock (pll_lock),
        .running (n_running), .hsync (n_hsync), .vsync (n_vsync), .de (n_de),
        .x (n_x), .y (n_y), .frame_start (n_frame_start), .rgb (n_rgb)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-18s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    initial begin
        int de_cnt, hs_cnt, vs_cnt, fs_cnt, rgb_nz, run_seen;

        reset    = 1'b1;
        pll_lock = 1'b1;
        #12;
        check("rst_running",  running,     0);
        check("rst_de",       de,          0);
        check("rst_x",        x,           0);
        check("rst_y",        y,           0);
        check("rst_fs",       frame_start, 0);
        check("rst_rgb",      rgb,         0);
        check("rst_hsync",    hsync,       0);
        check("rst_vsync",    vsync,       0);
        check("rst_nhsync",   n_hsync,     1);
        check("rst_nvsync",   n_vsync,     1);

        @(posedge clkin);
        #1;
        reset = 1'b0;

        // 2 sync + 1 IDLE->WAIT + 16 wait cycles = RUN on the 19th edge.
        repeat (18) tick();
        check("start_run_e18", running, 0);
        tick();
        check("start_run_e19", running, 1);
        check("start_de_e19",  de,      0);
        tick();
        check("first_de",      de,          1);
        check("first_fs",      frame_start, 1);
        check("first_x",       x,           0);
        check("first_y",       y,           0);

        for (int k = 0; k < FRAME; k++) begin
            de_s[k]  = de;      hs_s[k]  = hsync;   vs_s[k] = vsync;
            fs_s[k]  = frame_start;
            nhs_s[k] = n_hsync; nvs_s[k] = n_vsync;
            x_s[k]   = x;       y_s[k]   = y;       rgb_s[k] = rgb;
            tick();
        end

        de_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0; rgb_nz = 0;
        for (int k = 0; k < FRAME; k++) begin
            de_cnt += int'(de_s[k]);
            hs_cnt += int'(hs_s[k]);
            vs_cnt += int'(vs_s[k]);
            fs_cnt += int'(fs_s[k]);
            if (rgb_s[k] != 24'h0) rgb_nz++;
        end
        check("frame_de_count", de_cnt, 128);
        check("frame_hs_count", hs_cnt, 42);
        check("frame_vs_count", vs_cnt, 50);
        check("frame_fs_count", fs_cnt, 1);

        check("de_last_active", de_s[15], 1);
        check("x_last_active",  x_s[15],  15);
        check("de_fp_start",    de_s[16], 0);
        check("x_blank",        x_s[16],  0);
        check("y_line1",        y_s[28],  1);
        check("x_line1",        x_s[28],  3);
        check("de_vblank",      de_s[200], 0);
        check("y_vblank",       y_s[200],  0);
        check("hs_before",      hs_s[17], 0);
        check("hs_first",       hs_s[18], 1);
        check("hs_last",        hs_s[20], 1);
        check("hs_after",       hs_s[21], 0);
        check("vs_before",      vs_s[224], 0);
        check("vs_first",       vs_s[225], 1);
        check("vs_last",        vs_s[274], 1);
        check("vs_after",       vs_s[275], 0);
        check("nhs_idle",       nhs_s[17], 1);
        check("nhs_pulse",      nhs_s[18], 0);
        check("nvs_idle",       nvs_s[224], 1);
        check("nvs_pulse",      nvs_s[225], 0);

`ifdef VTG_PATTERN_EN
        check("rgb_bar0_x0",  rgb_s[0],  24'hFFFFFF);
        check("rgb_bar0_x1",  rgb_s[1],  24'hFFFFFF);
        check("rgb_bar1_x2",  rgb_s[2],  24'hFFFF00);
        check("rgb_bar2_y1",  rgb_s[29], 24'h00FFFF);
        check("rgb_bar6_x12", rgb_s[12], 24'h0000FF);
        check("rgb_bar7_x15", rgb_s[15], 24'h000000);
        check("rgb_hblank",   rgb_s[20], 24'h000000);
`else
        check("rgb_tied_x0",  rgb_s[0], 0);
        check("rgb_nonzero",  rgb_nz,   0);
`endif

        check("frame2_fs", frame_start, 1);
        check("frame2_x",  x,           0);
        check("frame2_de", de,          1);

        // Drop lock at y=4, x=8.
        repeat (108) tick();
        check("loss_x_pre", x, 8);
        check("loss_y_pre", y, 4);
        pll_lock = 1'b0;
        tick();
        check("loss_e1_run", running, 1);
        check("loss_e1_x",   x,       9);
        tick();
        check("loss_e2_de",  de,      1);
        check("loss_e2_x",   x,       10);
        tick();
        check("loss_run",    running,     0);
        check("loss_de",     de,          0);
        check("loss_x",      x,           0);
        check("loss_y",      y,           0);
        check("loss_fs",     frame_start, 0);
        check("loss_hsync",  hsync,       0);
        check("loss_nhsync", n_hsync,     1);
        check("loss_nvsync", n_vsync,     1);

        // Re-lock, then glitch low for 3 cycles at wait count 8.
        pll_lock = 1'b1;
        repeat (10) tick();
        check("glitch_pre_run", running, 0);
        pll_lock = 1'b0;
        run_seen = 0;
        repeat (3) begin
            tick();
            if (running) run_seen++;
        end
        pll_lock = 1'b1;
        for (int e = 14; e <= 31; e++) begin
            tick();
            if (running) run_seen++;
            if (e == 19) check("glitch_run_q19", running, 0);
        end
        check("glitch_run_seen", run_seen, 0);
        tick();
        check("relock_run", running, 1);
        tick();
        check("relock_de", de,          1);
        check("relock_fs", frame_start, 1);
        check("relock_x",  x,           0);
        check("relock_y",  y,           0);

        // Asynchronous reset between clock edges while mid-line.
        tick();
        tick();
        check("pre_rst_de", de, 1);
        check("pre_rst_x",  x,  2);
        #3;
        reset = 1'b1;
        #1;
        check("arst_run",    running,     0);
        check("arst_de",     de,          0);
        check("arst_x",      x,           0);
        check("arst_fs",     frame_start, 0);
        check("arst_hsync",  hsync,       0);
        check("arst_vsync",  vsync,       0);
        check("arst_nhsync", n_hsync,     1);
        check("arst_nvsync", n_vsync,     1);
        check("arst_rgb",    rgb,         0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
